// File: rtl/icache_pkg.sv
// Shared types, default geometry and derived widths for the set-associative icache.
// Optional performance counters in the top are enabled with ICACHE_PERF_CNT_EN.
package icache_pkg;

    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int p = 1; p < value; p = p * 2) begin
            bits++;
        end
        return bits;
    endfunction

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_LINE_WIDTH = 128;
    localparam int DEF_NUM_SETS   = 4;
    localparam int DEF_NUM_WAYS   = 2;

    localparam int OFF_W = clog2(DEF_LINE_WIDTH / 8);
    localparam int IDX_W = clog2(DEF_NUM_SETS);
    localparam int TAG_W = DEF_ADDR_WIDTH - OFF_W - IDX_W;
    localparam int WAY_W = (DEF_NUM_WAYS > 1) ? clog2(DEF_NUM_WAYS) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2,
        RESP      = 2'd3
    } icache_state_t;

    typedef logic [DEF_LINE_WIDTH-1:0] line_t;
    typedef logic [TAG_W-1:0]          tag_t;

endpackage

// File: rtl/icache_plru.sv
// Per-set tree pseudo-LRU: victim lookup for one set, one update per cycle.
// Tree bits point toward the next victim; an access flips its path away.
module icache_plru
    import icache_pkg::*;
#(
    parameter int NUM_SETS = 4,
    parameter int NUM_WAYS = 2,
    localparam int IDX_BITS = (NUM_SETS > 1) ? clog2(NUM_SETS) : 1,
    localparam int WAY_BITS = (NUM_WAYS > 1) ? clog2(NUM_WAYS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic [IDX_BITS-1:0] victim_set,
    output logic [WAY_BITS-1:0] victim_way,
    input  logic                upd_valid,
    input  logic [IDX_BITS-1:0] upd_set,
    input  logic [WAY_BITS-1:0] upd_way
);

    generate
        if (NUM_WAYS == 1) begin : g_direct
            logic unused_plru;
            assign unused_plru = ^{clock, reset, clear, victim_set, upd_valid, upd_set, upd_way};
            assign victim_way  = '0;
        end else begin : g_tree
            logic [NUM_WAYS-2:0] tree [NUM_SETS];
            logic [NUM_WAYS-2:0] tree_upd;

            always_comb begin
                logic [NUM_WAYS-2:0] t;
                logic [WAY_BITS-1:0] node;
                logic [WAY_BITS-1:0] way;
                t    = tree[victim_set];
                node = '0;
                way  = '0;
                for (int l = 0; l < WAY_BITS; l++) begin
                    way  = WAY_BITS'((int'(way) << 1) | int'(t[node]));
                    node = WAY_BITS'(2 * int'(node) + 1 + int'(t[node]));
                end
                victim_way = way;
            end

            always_comb begin
                logic [WAY_BITS-1:0] node;
                logic                b;
                tree_upd = tree[upd_set];
                node     = '0;
                for (int l = 0; l < WAY_BITS; l++) begin
                    b              = upd_way[WAY_BITS-1-l];
                    tree_upd[node] = ~b;
                    node           = WAY_BITS'(2 * int'(node) + 1 + int'(b));
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    for (int s = 0; s < NUM_SETS; s++) tree[s] <= '0;
                end else if (clear) begin
                    for (int s = 0; s < NUM_SETS; s++) tree[s] <= '0;
                end else if (upd_valid) begin
                    tree[upd_set] <= tree_upd;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/icache_set_assoc.sv
// Blocking set-associative read-only instruction cache with handshaked fetch/memory sides.
// Define ICACHE_PERF_CNT_EN to add saturating hit_count/miss_count outputs.
module icache_set_assoc
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int NUM_SETS   = DEF_NUM_SETS,
    parameter int NUM_WAYS   = DEF_NUM_WAYS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic [LINE_WIDTH-1:0] rsp_data,
    output logic                  rsp_valid,
    input  logic                  flush,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    input  logic [LINE_WIDTH-1:0] mem_rsp_data,
    input  logic                  mem_rsp_valid
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int OFF_BITS = clog2(LINE_WIDTH / 8);
    localparam int SET_BITS = clog2(NUM_SETS);
    localparam int IDX_BITS = (SET_BITS > 0) ? SET_BITS : 1;
    localparam int TAG_BITS = ADDR_WIDTH - OFF_BITS - SET_BITS;
    localparam int WAY_BITS = (NUM_WAYS > 1) ? clog2(NUM_WAYS) : 1;

    icache_state_t state, state_next;

    logic [IDX_BITS-1:0]   req_idx, miss_idx;
    logic [TAG_BITS-1:0]   req_tag, miss_tag;
    logic [WAY_BITS-1:0]   hit_way, victim_way, plru_way, miss_way;
    logic [NUM_WAYS-1:0]   hit_vec, set_valid;
    logic                  hit, accept, fill, clear_all, flush_pend;
    logic                  lru_upd;
    logic [IDX_BITS-1:0]   lru_set;
    logic [WAY_BITS-1:0]   lru_way;

    logic [NUM_SETS-1:0]   valid    [NUM_WAYS];
    logic [TAG_BITS-1:0]   tag_mem  [NUM_WAYS][NUM_SETS];
    logic [LINE_WIDTH-1:0] data_mem [NUM_WAYS][NUM_SETS];

    logic unused_off;
    assign unused_off = ^req_addr[OFF_BITS-1:0];

    generate
        if (SET_BITS == 0) begin : g_one_set
            assign req_idx = '0;
        end else begin : g_sets
            assign req_idx = req_addr[OFF_BITS +: SET_BITS];
        end
    endgenerate
    assign req_tag = req_addr[ADDR_WIDTH-1 -: TAG_BITS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WAYS; gi++) begin : g_way
            assign set_valid[gi] = valid[gi][req_idx];
            assign hit_vec[gi]   = set_valid[gi] && (tag_mem[gi][req_idx] == req_tag);
        end
    endgenerate

    assign hit = |hit_vec;

    always_comb begin
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (hit_vec[w]) hit_way = WAY_BITS'(w);
        end
    end

    // Descending scan so the lowest-index invalid way is the last to win.
    always_comb begin
        victim_way = plru_way;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!set_valid[w]) victim_way = WAY_BITS'(w);
        end
    end

    assign req_ready     = reset && (state == IDLE);
    assign accept        = req_valid && req_ready;
    assign mem_req_valid = (state == MISS_REQ);
    assign fill          = (state == MISS_WAIT) && mem_rsp_valid;
    assign clear_all     = ((state == IDLE) && flush) ||
                           ((state == RESP) && (flush_pend || flush));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (accept && !hit) state_next = MISS_REQ;
            MISS_REQ:  if (mem_req_ready)  state_next = MISS_WAIT;
            MISS_WAIT: if (mem_rsp_valid)  state_next = RESP;
            RESP:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            miss_idx     <= '0;
            miss_tag     <= '0;
            miss_way     <= '0;
            mem_req_addr <= '0;
            flush_pend   <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
        end else begin
            state     <= state_next;
            rsp_valid <= (accept && hit) || fill;
            if (accept && !hit) begin
                miss_idx     <= req_idx;
                miss_tag     <= req_tag;
                miss_way     <= victim_way;
                mem_req_addr <= {req_addr[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};
            end
            if (accept && hit) begin
                rsp_data <= data_mem[hit_way][req_idx];
            end else if (fill) begin
                rsp_data <= mem_rsp_data;
            end
            if (state == RESP) begin
                flush_pend <= 1'b0;
            end else if (flush && (state != IDLE)) begin
                flush_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < NUM_WAYS; w++) valid[w] <= '0;
        end else if (clear_all) begin
            for (int w = 0; w < NUM_WAYS; w++) valid[w] <= '0;
        end else if (fill) begin
            valid[miss_way][miss_idx] <= 1'b1;
        end
    end

    // Line and tag storage carry no reset; only the valid bits gate them.
    always_ff @(posedge clock) begin
        if (fill) begin
            data_mem[miss_way][miss_idx] <= mem_rsp_data;
            tag_mem[miss_way][miss_idx]  <= miss_tag;
        end
    end

    assign lru_upd = (accept && hit) || fill;
    assign lru_set = fill ? miss_idx : req_idx;
    assign lru_way = fill ? miss_way : hit_way;

    icache_plru #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS)
    ) u_plru (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear_all),
        .victim_set (req_idx),
        .victim_way (plru_way),
        .upd_valid  (lru_upd),
        .upd_set    (lru_set),
        .upd_way    (lru_way)
    );

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (accept && hit && (hit_count != '1))    hit_count  <= hit_count + 32'd1;
            if (accept && !hit && (miss_count != '1))  miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/icache_set_assoc.md
Name: icache_set_assoc

Overview:
Parametrised set-associative, read-only instruction cache between fetch and the memory hierarchy. It succeeds the fixed-size blocking icache with the following changes:
- generic geometry;
- valid/ready handshakes on both sides;
- explicit miss FSM;
- whole-cache invalidate;
- registered responses.

It serves one hit per cycle and blocks on a miss until the line is filled.

Parameters:
ADDR_WIDTH, 32, byte address width
LINE_WIDTH, 128, cache line width in bits (power of 2, ≥ 32)
NUM_SETS, 4, number of sets (power of 2, ≥ 1)
NUM_WAYS, 2, associativity (power of 2, ≥ 1; 1 = direct mapped)

Ports:
clock  in  1  system clock
reset  in  1  reset; one clock; reset is asynchronous and active-low
req_addr  in  ADDR_WIDTH  fetch byte address
req_valid  in  1  fetch request valid
req_ready  out  1  cache can accept a request this cycle
rsp_data  out  LINE_WIDTH  line returned to fetch
rsp_valid  out  1  rsp_data valid (single-cycle pulse)
flush  in  1  invalidate all lines
mem_req_addr  out  ADDR_WIDTH  line-aligned miss address (offset bits zero)
mem_req_valid  out  1  miss request valid
mem_req_ready  in  1  memory accepts request
mem_rsp_data  in  LINE_WIDTH  fill line
mem_rsp_valid  in  1  fill valid (single-cycle pulse)

Behaviour:
- Address split:
  - OFF = log2(LINE_WIDTH/8) low bits ignored;
  - index = next log2(NUM_SETS) bits (zero-width if NUM_SETS = 1);
  - tag = remaining upper bits.
- Storage:
  - data, tag and valid per set/way;
  - valid bits only are reset (to 0); data/tag arrays are not reset.
- FSM states: IDLE, MISS_REQ, MISS_WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - Request accepted on req_valid & req_ready; lookup in the same cycle.
  - Hit: rsp_valid = 1 with the hit line in the next cycle; stay IDLE. Back-to-back hits give 1 response per cycle.
  - Miss: latch address/index/tag and victim way; go to MISS_REQ; no response.
- MISS_REQ:
  - mem_req_valid = 1, mem_req_addr = latched line address; both held stable until mem_req_ready.
  - On handshake go to MISS_WAIT.
- MISS_WAIT:
  - On mem_rsp_valid, write data/tag to the victim way, set valid, update LRU; go to RESP.
  - mem_rsp_valid in any other state is ignored.
- RESP:
  - rsp_valid = 1, rsp_data = filled line; next state IDLE.
  - Miss latency: request to rsp_valid = 2 cycles + memory handshake and fill delay. Minimum 3 cycles when mem_req_ready is already high and mem_rsp_valid arrives the cycle after the request handshake.
- req_ready = 0 in every state except IDLE.
- Victim selection:
  - lowest-index invalid way in the set if any;
  - otherwise the tree pseudo-LRU victim.
  - LRU is updated on every hit and every fill.
  - NUM_WAYS = 1: no LRU state, victim is always way 0.
- Flush:
  - In IDLE: all valid bits clear at the next edge. A request accepted in the same cycle is looked up against the pre-flush state, and a hit response is still delivered.
  - Outside IDLE: flush is latched and applied on the RESP→IDLE transition. This also invalidates the just-filled line; the in-flight response is still delivered.
  - LRU state is reset on flush.
- Reset values: req_ready = 0 during reset, then 1 (IDLE); rsp_valid = 0; rsp_data = 0; mem_req_valid = 0; mem_req_addr = 0; FSM = IDLE; LRU = 0; all valid bits 0.
- Reset mid-miss: the miss is abandoned; a late mem_rsp_valid after reset is ignored (state IDLE).
- Simultaneous hit and LRU update on the same set: the update uses the accessed way only.

Optional Feature:
ICACHE_PERF_CNT_EN.
- Defined:
  - adds outputs hit_count and miss_count, 32 bits each;
  - they increment on each accepted hit / miss, saturate at all-ones, and reset to 0 (asynchronous, active-low reset; flush does not clear them).
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package icache_pkg holds:
  - derived widths (OFF_W, IDX_W, TAG_W, WAY_W);
  - FSM state enum icache_state_t;
  - line/tag typedefs.
- One sub-module, icache_plru: per-set tree pseudo-LRU with a victim read port (set → way) and an update port (valid, set, way). Parametrised by NUM_SETS and NUM_WAYS.

Test Plan:
All cases use defaults: OFF = [3:0], index = [5:4], tag = [31:6].
- Cold miss:
  - Stimulus: req 0x0000_0040, memory ready immediately, fill 0xA5.. one cycle later.
  - Required: mem_req_addr = 0x40; rsp_valid in cycle 3 with 0xA5..; req_ready low for cycles 1–3.
- Hit stream:
  - Stimulus: after the cold miss, req 0x44, 0x48, 0x4C back-to-back.
  - Required: 3 consecutive rsp_valid pulses with the same line; mem_req_valid stays 0.
- LRU:
  - Stimulus: fill 0x040 and 0x140 (set 0, both ways), access 0x040, then miss 0x240.
  - Required: the 0x140 way is evicted; a re-request of 0x040 hits and 0x140 misses.
- Backpressure:
  - Stimulus: miss with mem_req_ready low for 5 cycles.
  - Required: mem_req_valid/addr held stable for all 5 cycles; exactly one handshake.
- Flush during miss:
  - Stimulus: assert flush in MISS_WAIT.
  - Required: the fill response is still delivered; the next request to the same address misses.
- Reset mid-miss:
  - Stimulus: assert reset in MISS_WAIT, then pulse mem_rsp_valid after release.
  - Required: no rsp_valid; all lookups miss.
